// File: rtl/arbitro_transaccion_pkg.sv
// arbitro_transaccion_pkg: shared state encoding and widths for the transaction arbiter.
package arbitro_transaccion_pkg;
  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;
  localparam int CNT_W  = 5;
  localparam int DEST_W = 2;
endpackage

// File: rtl/arbitro_transaccion_rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin grant, searching from last+1 upward.
module rr_arbiter_4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_last,
  output logic [3:0] o_grant,
  output logic [1:0] o_idx,
  output logic       o_valid
);
  always_comb begin
    o_idx   = 2'd0;
    o_valid = 1'b0;
    // descending scan so the closest requester after i_last wins
    for (int k = 3; k >= 0; k--)
      if (i_req[i_last + 2'(k + 1)]) begin
        o_idx   = i_last + 2'(k + 1);
        o_valid = 1'b1;
      end
    o_grant = o_valid ? 4'b0001 << o_idx : 4'b0000;
  end
endmodule

// File: rtl/arbitro_transaccion.sv
// arbitro_transaccion: round-robin scheduler from four input FIFOs to four output FIFOs
// with config sequencing and per-destination delivery counters.
module arbitro_transaccion
  import arbitro_transaccion_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold_input,
  input  logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold_input,
  input  logic [3:0]                fifo_in_empty,
  input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data0,
  input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data1,
  input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data2,
  input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data3,
  input  logic [3:0]                fifo_out_almost_full,
  input  logic                      req,
  input  logic [1:0]                idx,
  output logic [3:0]                pop_FIFO_in,
  output logic [3:0]                push_FIFO_out,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold,
  output logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold,
  output logic                      idle,
  output logic [CNT_W-1:0]          data,
  output logic                      valid
);
  state_t                    r_state;
  state_t                    w_next;
  logic [1:0]                r_last;
  logic [CNT_W-1:0]          r_cnt [4];
  logic [FIFO_WORD_SIZE-1:0] w_word [4];
  logic [3:0]                w_req;
  logic [3:0]                w_grant;
  logic [1:0]                w_gidx;
  logic                      w_gv;
  logic [FIFO_WORD_SIZE-1:0] w_sel;
  logic [DEST_W-1:0]         w_dest;

  assign w_word[0] = fifo_in_data0;
  assign w_word[1] = fifo_in_data1;
  assign w_word[2] = fifo_in_data2;
  assign w_word[3] = fifo_in_data3;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_req
      assign w_req[i] = !fifo_in_empty[i] && r_state == ST_ACTIVE && !init &&
                        !fifo_out_almost_full[w_word[i][FIFO_WORD_SIZE-1 -: DEST_W]];
    end
  endgenerate

  rr_arbiter_4 u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_grant(w_grant),
    .o_idx  (w_gidx),
    .o_valid(w_gv)
  );

  assign pop_FIFO_in = w_grant;
  assign w_sel       = w_word[w_gidx];
  assign w_dest      = w_sel[FIFO_WORD_SIZE-1 -: DEST_W];
  assign idle        = r_state == ST_IDLE;

  // leaving ACTIVE waits for the in-flight push so idle implies an empty pipeline
  always_comb
    w_next = r_state == ST_RESET ? ST_INIT :
             r_state == ST_INIT  ? (init ? ST_INIT : ST_IDLE) :
             init                ? ST_INIT :
             r_state == ST_IDLE  ? (&fifo_in_empty ? ST_IDLE : ST_ACTIVE) :
             (&fifo_in_empty && push_FIFO_out == 4'b0000) ? ST_IDLE : ST_ACTIVE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                <= ST_RESET;
      r_last                 <= 2'd3;
      push_FIFO_out          <= '0;
      data_out               <= '0;
      almost_full_threshold  <= '0;
      almost_empty_threshold <= '0;
      data                   <= '0;
      valid                  <= 1'b0;
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      r_state       <= w_next;
      push_FIFO_out <= w_gv ? 4'b0001 << w_dest : 4'b0000;
      valid         <= req;
      if (w_gv) begin
        r_last   <= w_gidx;
        data_out <= w_sel;
      end
      if (r_state == ST_INIT) begin
        almost_full_threshold  <= almost_full_threshold_input;
        almost_empty_threshold <= almost_empty_threshold_input;
      end
      if (req) data <= r_cnt[idx];
      for (int k = 0; k < 4; k++)
        if (push_FIFO_out[k]) r_cnt[k] <= r_cnt[k] + 1'b1;
    end
  end
endmodule

// File: tb/tb_arbitro_transaccion.sv
// tb_arbitro_transaccion: directed + random bench with queue-based FIFO model.
module tb_arbitro_transaccion;
  typedef logic [9:0] word_t;

  logic       clk = 1'b0;
  logic       reset, init, req;
  logic [2:0] aft_in, aet_in;
  logic [3:0] fifo_in_empty, fifo_out_almost_full;
  word_t      d0, d1, d2, d3;
  logic [1:0] idx;
  logic [3:0] pop_FIFO_in, push_FIFO_out;
  word_t      data_out;
  logic [2:0] aft, aet;
  logic       idle, valid;
  logic [4:0] data;

  always #5 clk = ~clk;

  arbitro_transaccion dut (
    .clk(clk), .reset(reset), .init(init),
    .almost_full_threshold_input(aft_in), .almost_empty_threshold_input(aet_in),
    .fifo_in_empty(fifo_in_empty),
    .fifo_in_data0(d0), .fifo_in_data1(d1), .fifo_in_data2(d2), .fifo_in_data3(d3),
    .fifo_out_almost_full(fifo_out_almost_full), .req(req), .idx(idx),
    .pop_FIFO_in(pop_FIFO_in), .push_FIFO_out(push_FIFO_out), .data_out(data_out),
    .almost_full_threshold(aft), .almost_empty_threshold(aet),
    .idle(idle), .data(data), .valid(valid)
  );

  int checks = 0, failures = 0;
  word_t q [4][$];
  int mstate, mlast, mgrant, mrd, mcnt[4];
  logic [3:0] mpush;
  word_t mdata;
  logic mvalid;
  logic [2:0] maft, maet;
  int plog[$];
  int npush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mstate = 0; mlast = 3; mpush = 0; mdata = 0; mrd = 0; mvalid = 0; maft = 0; maet = 0;
    for (int d = 0; d < 4; d++) mcnt[d] = 0;
  endtask

  task automatic drive();
    for (int j = 0; j < 4; j++) fifo_in_empty[j] = q[j].size() == 0;
    d0 = q[0].size() > 0 ? q[0][0] : 10'h0;
    d1 = q[1].size() > 0 ? q[1][0] : 10'h0;
    d2 = q[2].size() > 0 ? q[2][0] : 10'h0;
    d3 = q[3].size() > 0 ? q[3][0] : 10'h0;
  endtask

  // one clock: check outputs at negedge against the model, then advance the model
  task automatic cycle();
    logic [3:0] epop;
    int ns;
    bit any;
    drive();
    @(negedge clk);
    mgrant = -1;
    if (mstate == 3 && !init)
      for (int k = 1; k <= 4; k++) begin
        int j = (mlast + k) % 4;
        if (mgrant < 0 && q[j].size() > 0 && !fifo_out_almost_full[q[j][0][9:8]]) mgrant = j;
      end
    epop = mgrant < 0 ? 4'b0 : 4'(1 << mgrant);
    chk("pop", pop_FIFO_in, epop);
    chk("push", push_FIFO_out, mpush);
    chk("data_out", data_out, mdata);
    chk("idle", idle, 32'(mstate == 2));
    chk("valid", valid, mvalid);
    chk("data", data, mrd);
    chk("af_thr", aft, maft);
    chk("ae_thr", aet, maet);
    for (int j = 0; j < 4; j++) if (pop_FIFO_in[j]) plog.push_back(j);
    if (push_FIFO_out != 0) npush++;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      any = 0;
      for (int j = 0; j < 4; j++) if (q[j].size() > 0) any = 1;
      mvalid = req;
      if (req) mrd = mcnt[idx];
      for (int d = 0; d < 4; d++) if (mpush[d]) mcnt[d] = (mcnt[d] + 1) % 32;
      if (mstate == 1) begin maft = aft_in; maet = aet_in; end
      ns = mstate == 0 ? 1 : mstate == 1 ? (init ? 1 : 2) : init ? 1 :
           mstate == 2 ? (any ? 3 : 2) : (!any && mpush == 0) ? 2 : 3;
      mpush = 0;
      if (mgrant >= 0) begin
        mpush = 4'(1 << q[mgrant][0][9:8]);
        mdata = q[mgrant][0];
        mlast = mgrant;
      end
      mstate = ns;
    end
    if (mgrant >= 0) void'(q[mgrant].pop_front());
    #1;
  endtask

  task automatic chk_order(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_len"}, plog.size(), 4);
    for (int k = 0; k < 4; k++) chk(tag, plog.size() > k ? plog[k] : -1, e[k]);
  endtask

  initial begin
    bit seen;
    reset = 1; init = 0; req = 0; idx = 0; aft_in = 0; aet_in = 0;
    fifo_out_almost_full = 0; npush = 0;
    drive();
    @(posedge clk); #1;
    model_reset();
    repeat (2) cycle();
    chk("rst_idle", idle, 0);
    chk("rst_push", push_FIFO_out, 0);
    // configuration phase
    reset = 0; init = 1; aft_in = 3'd6; aet_in = 3'd2;
    repeat (3) cycle();
    init = 0;
    repeat (2) cycle();
    chk("cfg_af", aft, 6);
    chk("cfg_ae", aet, 2);
    chk("cfg_idle", idle, 1);
    aft_in = 3'd1; aet_in = 3'd1;
    // one word per FIFO, dest = own index
    plog.delete();
    for (int j = 0; j < 4; j++) q[j].push_back({2'(j), 8'(8'h0A + j)});
    repeat (7) cycle();
    chk_order("rr_order", 0, 1, 2, 3);
    // FIFOs 0 and 2 contend for a blocked destination
    plog.delete();
    fifo_out_almost_full = 4'b0010;
    repeat (2) begin q[0].push_back({2'd1, 8'h30}); q[2].push_back({2'd1, 8'h50}); end
    repeat (4) cycle();
    chk("blocked_pops", plog.size(), 0);
    fifo_out_almost_full = 4'b0000;
    repeat (6) cycle();
    chk_order("af_order", 0, 2, 0, 2);
    // init right after a pop from FIFO 1
    plog.delete();
    q[1].push_back({2'd2, 8'h55});
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      cycle();
      seen = plog.size() > 0 && plog[plog.size() - 1] == 1;
    end
    chk("wait_pop1", 32'(seen), 1);
    init = 1; aft_in = 3'd5; aet_in = 3'd3;
    q[2].push_back({2'd0, 8'h77});
    plog.delete(); npush = 0;
    repeat (3) cycle();
    chk("init_pushes", npush, 1);
    chk("init_pops", plog.size(), 0);
    init = 0;
    repeat (6) cycle();
    chk("cfg2_af", aft, 5);
    // 33 words to dest 3; one earlier dest-3 delivery makes 34 -> 2 mod 32
    for (int n = 0; n < 33; n++) q[3].push_back({2'd3, 8'(n)});
    repeat (40) cycle();
    req = 1; idx = 2'd3;
    cycle();
    req = 0;
    chk("cnt3_data", data, 2);
    chk("cnt3_valid", valid, 1);
    cycle();
    chk("cnt3_valid_off", valid, 0);
    chk("cnt3_hold", data, 2);
    // reset one cycle after a pop
    q[0].push_back({2'd1, 8'h11}); q[0].push_back({2'd1, 8'h12});
    plog.delete(); seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin cycle(); seen = plog.size() > 0; end
    chk("wait_pop0", 32'(seen), 1);
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_mid_push", push_FIFO_out, 0);
    chk("rst_mid_idle", idle, 0);
    req = 1; idx = 2'd1;
    cycle();
    req = 0;
    chk("rst_cnt1", data, 0);
    repeat (4) cycle();
    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int j = $urandom_range(0, 3);
        if (q[j].size() < 6) q[j].push_back(10'($urandom));
      end
      fifo_out_almost_full = 4'($urandom) & 4'($urandom);
      req = 1'($urandom);
      idx = 2'($urandom);
      aft_in = 3'($urandom); aet_in = 3'($urandom);
      init = $urandom_range(0, 49) == 0;
      reset = $urandom_range(0, 199) == 0;
      cycle();
    end
    reset = 0; init = 0; req = 0; fifo_out_almost_full = 0;
    repeat (40) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
